// File: rtl/operand_addr_seq.sv
// Operand read-address sequencer: expands one micro-instruction into per-beat
// register-file read addresses. Optional `OPSEQ_BACK2BACK_EN` removes the idle bubble between instructions.
module operand_addr_seq #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 3,
    parameter int GRP_W    = 2,
    parameter int SRC_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      uinstr_valid_i,
    output logic                      uinstr_ready_o,
    input  logic [NUM_SRC*ADDR_W-1:0] uinstr_vrs_i,
    input  logic [NUM_SRC-1:0]        uinstr_en_i,
    input  logic [GRP_W-1:0]          uinstr_len_i,
    output logic                      rd_addr_valid_o,
    input  logic                      rd_addr_ready_i,
    output logic [ADDR_W-1:0]         rd_addr_o,
    output logic [SRC_ID_W-1:0]       rd_src_id_o,
    output logic                      rd_last_o,
    output logic                      busy_o
);

    // state | meaning
    // IDLE  | waiting for a micro-instruction, no beat presented
    // ISSUE | presenting beat (ptr_q, off_q) on the read-address channel
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_SRC*ADDR_W-1:0] vrs_q, vrs_d;
    logic [NUM_SRC-1:0]        en_q, en_d;
    logic [GRP_W-1:0]          len_q, len_d;
    logic [GRP_W-1:0]          off_q, off_d;
    logic [SRC_ID_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      last_q, last_d;
    logic                      accept;
    logic                      fire;

    function automatic logic [SRC_ID_W-1:0] lowest_from(input logic [NUM_SRC-1:0] m, input int lo);
        logic [SRC_ID_W-1:0] r;
        r = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (m[k] && k >= lo) r = SRC_ID_W'(k);
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [NUM_SRC-1:0] m, input logic [SRC_ID_W-1:0] p);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (m[k] && k > int'(p)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [NUM_SRC*ADDR_W-1:0] v,
                                                  input logic [SRC_ID_W-1:0] p);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (SRC_ID_W'(k) == p) r = v[k*ADDR_W +: ADDR_W];
        end
        return r;
    endfunction

    assign rd_addr_valid_o = (state_q == ISSUE);
    assign busy_o          = (state_q == ISSUE);
    assign rd_addr_o       = addr_q;
    assign rd_src_id_o     = ptr_q;
    assign rd_last_o       = last_q;

`ifdef OPSEQ_BACK2BACK_EN
    // Accept the next instruction while the final beat is being handed off.
    assign uinstr_ready_o = (state_q == IDLE) ||
                            ((state_q == ISSUE) && last_q && rd_addr_ready_i);
`else
    assign uinstr_ready_o = (state_q == IDLE);
`endif

    assign accept = uinstr_valid_i && uinstr_ready_o;
    assign fire   = rd_addr_valid_o && rd_addr_ready_i;

    always_comb begin
        state_d = state_q;
        vrs_d   = vrs_q;
        en_d    = en_q;
        len_d   = len_q;
        off_d   = off_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                if (fire) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else if (off_q < len_q) begin
                        off_d = off_q + 1'b1;
                    end else begin
                        off_d = '0;
                        ptr_d = lowest_from(en_q, int'(ptr_q) + 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            vrs_d   = uinstr_vrs_i;
            en_d    = uinstr_en_i;
            len_d   = uinstr_len_i;
            off_d   = '0;
            ptr_d   = lowest_from(uinstr_en_i, 0);
            state_d = (|uinstr_en_i) ? ISSUE : IDLE;
        end

        // Beat outputs are precomputed from the next pointer so they leave a flop.
        addr_d = base_of(vrs_d, ptr_d) + ADDR_W'(off_d);
        last_d = (off_d == len_d) && !any_above(en_d, ptr_d);
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            vrs_q   <= '0;
            en_q    <= '0;
            len_q   <= '0;
            off_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vrs_q   <= vrs_d;
            en_q    <= en_d;
            len_q   <= len_d;
            off_q   <= off_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_operand_addr_seq.sv
// Bench for operand_addr_seq: directed vector table, hand sequences for reset
// and back-to-back, and random instructions checked against a beat-list model.
module tb_operand_addr_seq;

    localparam int ADDR_W   = 5;
    localparam int NUM_SRC  = 3;
    localparam int GRP_W    = 2;
    localparam int SRC_ID_W = 2;
    localparam int VW       = NUM_SRC * ADDR_W;

    logic                clk_i = 1'b0;
    logic                arst_ni;
    logic                uinstr_valid_i;
    logic                uinstr_ready_o;
    logic [VW-1:0]       uinstr_vrs_i;
    logic [NUM_SRC-1:0]  uinstr_en_i;
    logic [GRP_W-1:0]    uinstr_len_i;
    logic                rd_addr_valid_o;
    logic                rd_addr_ready_i;
    logic [ADDR_W-1:0]   rd_addr_o;
    logic [SRC_ID_W-1:0] rd_src_id_o;
    logic                rd_last_o;
    logic                busy_o;

    operand_addr_seq #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .GRP_W   (GRP_W)
    ) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .uinstr_valid_i  (uinstr_valid_i),
        .uinstr_ready_o  (uinstr_ready_o),
        .uinstr_vrs_i    (uinstr_vrs_i),
        .uinstr_en_i     (uinstr_en_i),
        .uinstr_len_i    (uinstr_len_i),
        .rd_addr_valid_o (rd_addr_valid_o),
        .rd_addr_ready_i (rd_addr_ready_i),
        .rd_addr_o       (rd_addr_o),
        .rd_src_id_o     (rd_src_id_o),
        .rd_last_o       (rd_last_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [SRC_ID_W-1:0] src;
        logic                last;
    } beat_t;

    typedef struct {
        string             name;
        logic [VW-1:0]     vrs;
        logic [NUM_SRC-1:0] en;
        logic [GRP_W-1:0]  len;
        int                stall_beat;
        int                exp_beats;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected beat list: every enabled operand in ascending order, each expanded
    // into len+1 consecutive addresses modulo 2^ADDR_W.
    task automatic build_model(input logic [VW-1:0] vrs, input logic [NUM_SRC-1:0] en,
                               input logic [GRP_W-1:0] len, output beat_t q[$]);
        beat_t b;
        q = {};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (en[k]) begin
                for (int o = 0; o <= int'(len); o++) begin
                    b.addr = ADDR_W'((int'(vrs[k*ADDR_W +: ADDR_W]) + o) % (1 << ADDR_W));
                    b.src  = SRC_ID_W'(k);
                    b.last = 1'b0;
                    q.push_back(b);
                end
            end
        end
        if (q.size() > 0) begin
            b = q[q.size()-1];
            b.last = 1'b1;
            q[q.size()-1] = b;
        end
    endtask

    task automatic run_instr(input string tag, input logic [VW-1:0] vrs, input logic [NUM_SRC-1:0] en,
                             input logic [GRP_W-1:0] len, input int pct, input int stall_beat,
                             output int nbeats, output logic [ADDR_W-1:0] last_addr);
        beat_t q[$];
        beat_t exp_b, got, prev;
        int    cyc, stall_left;
        logic  rdy, have_prev, done;
        build_model(vrs, en, len, q);
        nbeats = 0;
        last_addr = '0;
        stall_left = 4;
        @(negedge clk_i);
        uinstr_vrs_i    = vrs;
        uinstr_en_i     = en;
        uinstr_len_i    = len;
        uinstr_valid_i  = 1'b1;
        rd_addr_ready_i = 1'b1;
        #1;
        cyc = 0;
        while (!uinstr_ready_o && cyc < 20) begin
            @(negedge clk_i); #1; cyc++;
        end
        if (!uinstr_ready_o) begin
            check({tag, "_accept_timeout"}, uinstr_ready_o, 1'b1);
            uinstr_valid_i = 1'b0;
            return;
        end
        @(negedge clk_i); #1;
        uinstr_valid_i = 1'b0;
        if (q.size() == 0) begin
            check({tag, "_empty_idle"}, {rd_addr_valid_o, busy_o, uinstr_ready_o}, 3'b001);
            rd_addr_ready_i = 1'b0;
            return;
        end
        check({tag, "_first_valid"}, rd_addr_valid_o, 1'b1);
        have_prev = 1'b0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            rdy = (int'($urandom_range(99)) < pct);
            if (nbeats == stall_beat && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            rd_addr_ready_i = rdy;
            uinstr_valid_i  = $urandom_range(1) == 1 && !rd_last_o;
            uinstr_vrs_i    = VW'($urandom);
            uinstr_en_i     = NUM_SRC'($urandom);
            uinstr_len_i    = GRP_W'($urandom);
            got = {rd_addr_o, rd_src_id_o, rd_last_o};
            if (have_prev) check({tag, "_hold"}, {rd_addr_valid_o, got}, {1'b1, prev});
            if (rd_addr_valid_o && rdy) begin
                exp_b = q.pop_front();
                check({tag, "_beat"}, got, exp_b);
                nbeats++;
                last_addr = rd_addr_o;
                have_prev = 1'b0;
                done = (q.size() == 0);
            end else if (rd_addr_valid_o) begin
                have_prev = 1'b1;
                prev = got;
            end else begin
                check({tag, "_valid_drop"}, rd_addr_valid_o, 1'b1);
            end
            @(negedge clk_i); #1; cyc++;
        end
        rd_addr_ready_i = 1'b0;
        uinstr_valid_i  = 1'b0;
        if (!done) check({tag, "_timeout"}, q.size(), 0);
        check({tag, "_idle_after"}, {rd_addr_valid_o, busy_o, uinstr_ready_o}, 3'b001);
    endtask

    vec_t vecs[6];

    initial begin
        int nb, gap, exp_gap;
        logic [ADDR_W-1:0] la;
        logic acc, got_b;

        vecs[0] = '{"basic",    {5'd12, 5'd7, 5'd3},  3'b111, 2'd0, -1, 3, 5'd12};
        vecs[1] = '{"bp_stall", {5'd12, 5'd7, 5'd3},  3'b111, 2'd0,  1, 3, 5'd12};
        vecs[2] = '{"grp_wrap", {5'd0,  5'd5, 5'd30}, 3'b011, 2'd2, -1, 6, 5'd7};
        vecs[3] = '{"skip",     {5'd9,  5'd17, 5'd4}, 3'b101, 2'd1, -1, 4, 5'd10};
        vecs[4] = '{"empty",    {5'd9,  5'd17, 5'd4}, 3'b000, 2'd1, -1, 0, 5'd0};
        vecs[5] = '{"op1_wrap", {5'd3,  5'd29, 5'd8}, 3'b010, 2'd3, -1, 4, 5'd0};

        arst_ni         = 1'b0;
        uinstr_valid_i  = 1'b0;
        uinstr_vrs_i    = '0;
        uinstr_en_i     = '0;
        uinstr_len_i    = '0;
        rd_addr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset", {uinstr_ready_o, rd_addr_valid_o, rd_last_o, busy_o, rd_addr_o, rd_src_id_o},
              {1'b1, 3'b000, 5'd0, 2'd0});
        arst_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i].name, vecs[i].vrs, vecs[i].en, vecs[i].len, 100, vecs[i].stall_beat, nb, la);
            check({vecs[i].name, "_nbeats"}, nb, vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0) check({vecs[i].name, "_last_addr"}, la, vecs[i].exp_last);
        end

        // Reset after the second of six beats.
        @(negedge clk_i);
        uinstr_vrs_i    = {5'd0, 5'd5, 5'd30};
        uinstr_en_i     = 3'b011;
        uinstr_len_i    = 2'd2;
        uinstr_valid_i  = 1'b1;
        rd_addr_ready_i = 1'b1;
        @(negedge clk_i); #1;
        uinstr_valid_i = 1'b0;
        check("rst_beat0", {rd_addr_valid_o, rd_addr_o}, {1'b1, 5'd30});
        @(negedge clk_i); #1;
        check("rst_beat1", {rd_addr_valid_o, rd_addr_o}, {1'b1, 5'd31});
        @(negedge clk_i); #1;
        arst_ni = 1'b0;
        rd_addr_ready_i = 1'b0;
        @(negedge clk_i); #1;
        check("rst_mid", {uinstr_ready_o, rd_addr_valid_o, busy_o, rd_last_o, rd_addr_o, rd_src_id_o},
              {1'b1, 3'b000, 5'd0, 2'd0});
        arst_ni = 1'b1;
        run_instr("post_rst", {5'd20, 5'd10, 5'd1}, 3'b111, 2'd0, 100, -1, nb, la);
        check("post_rst_nbeats", nb, 3);
        check("post_rst_last", la, 5'd20);

        // Two single-beat instructions back to back.
        @(negedge clk_i);
        uinstr_vrs_i    = {5'd0, 5'd0, 5'd2};
        uinstr_en_i     = 3'b001;
        uinstr_len_i    = 2'd0;
        uinstr_valid_i  = 1'b1;
        rd_addr_ready_i = 1'b1;
        @(negedge clk_i); #1;
        check("b2b_a", {rd_addr_valid_o, rd_addr_o, rd_last_o}, {1'b1, 5'd2, 1'b1});
        uinstr_vrs_i   = {5'd0, 5'd0, 5'd8};
        uinstr_valid_i = 1'b1;
        #1;
        gap = 0;
        got_b = 1'b0;
        while (!got_b && gap < 6) begin
            acc = uinstr_ready_o;
            @(negedge clk_i); #1; gap++;
            if (acc) uinstr_valid_i = 1'b0;
            if (rd_addr_valid_o && rd_addr_o == 5'd8) got_b = 1'b1;
        end
`ifdef OPSEQ_BACK2BACK_EN
        exp_gap = 1;
`else
        exp_gap = 2;
`endif
        check("b2b_gap", gap, exp_gap);
        check("b2b_b", {rd_addr_valid_o, rd_addr_o, rd_src_id_o, rd_last_o}, {1'b1, 5'd8, 2'd0, 1'b1});
        uinstr_valid_i = 1'b0;
        @(negedge clk_i); #1;
        check("b2b_end", {rd_addr_valid_o, busy_o, uinstr_ready_o}, 3'b001);
        rd_addr_ready_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [VW-1:0]      rv;
            logic [NUM_SRC-1:0] re;
            logic [GRP_W-1:0]   rl;
            rv = VW'($urandom);
            re = NUM_SRC'($urandom_range(7));
            rl = GRP_W'($urandom_range(3));
            run_instr("rnd", rv, re, rl, 60, -1, nb, la);
            check("rnd_nbeats", nb, $countones(re) * (int'(rl) + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_addr_seq.md
Name: operand_addr_seq

Overview:
Parametrised successor to the micro-instruction read-address sequencer. It accepts one micro-instruction carrying NUM_SRC source register bases, a per-operand enable mask and a register-group length. It then issues one register-file read address per beat over a valid/ready channel. It sits between the micro-instruction queue and the vector register-file read port, and supports grouped registers and skipped operands.

Parameters:
ADDR_W, 5, register address width; addresses wrap modulo 2^ADDR_W
NUM_SRC, 3, number of source operand fields per micro-instruction (1..8)
GRP_W, 2, width of group-length field; group size = len+1, max 2^GRP_W
SRC_ID_W, max(1,$clog2(NUM_SRC)), derived width of operand index

Ports:
clk_i  in  1  clock, rising edge
arst_ni  in  1  reset, synchronous, active-low
uinstr_valid_i  in  1  micro-instruction valid
uinstr_ready_o  out  1  micro-instruction accept
uinstr_vrs_i  in  NUM_SRC*ADDR_W  operand base addresses; operand k at bits [k*ADDR_W +: ADDR_W]
uinstr_en_i  in  NUM_SRC  operand enable mask; bit k enables operand k
uinstr_len_i  in  GRP_W  group length minus 1, shared by all operands
rd_addr_valid_o  out  1  read address valid
rd_addr_ready_i  in  1  read port accept
rd_addr_o  out  ADDR_W  read address
rd_src_id_o  out  SRC_ID_W  operand index of current beat
rd_last_o  out  1  final beat of current instruction
busy_o  out  1  instruction in flight

Behaviour:
- Reset (arst_ni=0 at posedge): state IDLE. uinstr_ready_o=1; rd_addr_valid_o, rd_last_o and busy_o = 0; rd_addr_o and rd_src_id_o = 0. Reset mid-operation abandons the instruction with no further beats.
- States: IDLE, ISSUE.
- IDLE: uinstr_ready_o=1. On valid&&ready, latch vrs, en and len.
  - Mask zero: instruction consumed, no beats, stay IDLE.
  - Otherwise go to ISSUE. Operand pointer = lowest set en bit; group offset = 0.
- Latency: first beat is valid on the cycle after acceptance. All channel outputs are registered.
- ISSUE:
  - rd_addr_valid_o=1, rd_addr_o = vrs[ptr] + offset, truncated to ADDR_W (wrap; e.g. 31+1 -> 0).
  - rd_src_id_o = ptr; busy_o=1; uinstr_ready_o=0 (see optional feature).
- Beat advance occurs only on rd_addr_valid_o && rd_addr_ready_i:
  - If offset < len: offset+1.
  - Else: offset=0 and ptr = next set en bit above ptr.
- While ready is low, rd_addr_o, rd_src_id_o and rd_last_o are held stable and valid stays high. Valid never drops without a handshake, except on reset.
- Order: ascending operand index, ascending offset. Beats per instruction = popcount(en)*(len+1).
- rd_last_o=1 exactly on the final beat (highest enabled operand, offset==len). The handshake of that beat returns the block to IDLE. Valid is low the next cycle unless the optional feature applies.
- Inputs uinstr_* are ignored while uinstr_ready_o=0.
- rd_addr_ready_i asserted while valid=0 has no effect.

Optional Feature:
OPSEQ_BACK2BACK_EN
- Defined: uinstr_ready_o is also asserted in ISSUE during the cycle the rd_last_o beat is presented, and is combinationally gated by rd_addr_ready_i.
  - A new instruction accepted in the same cycle as the last-beat handshake issues its first beat on the next cycle, with zero bubble.
  - A zero-mask instruction accepted this way returns the block to IDLE.
- Undefined: uinstr_ready_o=1 only in IDLE; at least one idle cycle occurs between instructions.

Test Plan:
- Basic: vrs={3,7,12} (op0=3), en=3'b111, len=0, ready=1 → beats addr 3,7,12 with src_id 0,1,2; last only on 12; first valid 1 cycle after accept.
- Grouping+wrap: vrs op0=30, op1=5, en=3'b011, len=2 → addr 30,31,0,5,6,7; last on 7.
- Skip/empty: en=3'b101, vrs op0=4, op2=9, len=1 → 4,5,9,10. A following en=3'b000 is accepted with no beats and ready stays 1.
- Backpressure: during the basic test, hold rd_addr_ready_i=0 for 4 cycles on beat addr 7 → addr, src_id and valid stable; sequence resumes with 12.
- Reset mid-issue: drop arst_ni after the 2nd of 6 beats → next cycle valid=0, busy=0, ready=1; the next instruction starts cleanly from its op0.
- Back-to-back (OPSEQ_BACK2BACK_EN on vs off): two len=0, en=3'b001 instructions with vrs 2 then 8 → beats on consecutive cycles when defined; one idle cycle between them when undefined.
